// File: rtl/eeg_fir_mc.sv
// -----------------------------------------------------------------------------
// eeg_fir_mc
// Multi-channel, time-multiplexed symmetric (linear-phase) FIR band-pass filter
// for EEG sample streams. A single pre-adder / multiplier / accumulator is shared
// by all channels. Each channel has its own circular delay line. The TAPS/2
// unique coefficients are loaded at runtime.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   in_valid/in_ready         sample handshake
//   in_channel, in_sample     channel index and signed sample
//   coef_wr_en/addr/data      coefficient write (ignored while busy)
//   out_valid                 one-cycle pulse when out_data is updated
//   out_channel, out_data     channel and saturated result (held until next result)
//   out_sat                   out_data was clipped
//   busy                      MAC sweep in progress
// -----------------------------------------------------------------------------
module eeg_fir_mc #(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int TAPS     = 64,
    parameter int CHANNELS = 4,
    parameter int ACC_W    = 40,
    parameter int OUT_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [$clog2(CHANNELS)-1:0]   in_channel,
    input  logic signed [DATA_W-1:0]      in_sample,
    input  logic                          coef_wr_en,
    input  logic [$clog2(TAPS/2)-1:0]     coef_addr,
    input  logic signed [COEF_W-1:0]      coef_data,
    output logic                          out_valid,
    output logic [$clog2(CHANNELS)-1:0]   out_channel,
    output logic signed [OUT_W-1:0]       out_data,
    output logic                          out_sat,
    output logic                          busy
);

    localparam int HALF   = TAPS / 2;
    localparam int CH_W   = $clog2(CHANNELS);
    localparam int PTR_W  = $clog2(TAPS);
    localparam int K_W    = $clog2(HALF);
    localparam int PRE_W  = DATA_W + 1;
    localparam int PROD_W = PRE_W + COEF_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Circular pointer step forward, wrapping TAPS-1 -> 0.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_W'(TAPS - 1)) begin
            r = '0;
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    // Circular pointer step backward, wrapping 0 -> TAPS-1.
    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == '0) begin
            r = PTR_W'(TAPS - 1);
        end else begin
            r = p - PTR_W'(1);
        end
        return r;
    endfunction

    // Clip the accumulator into OUT_W bits; MSB of the result is the clip flag.
    // The value fits iff all bits from ACC_W-1 down to OUT_W-1 are equal.
    function automatic logic [OUT_W:0] sat_clip(input logic signed [ACC_W-1:0] a);
        logic [ACC_W-OUT_W:0] top;
        logic [OUT_W:0]       r;
        top = a[ACC_W-1:OUT_W-1];
        if ((&top) || !(|top)) begin
            r = {1'b0, a[OUT_W-1:0]};
        end else if (a[ACC_W-1]) begin
            r = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            r = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
        end
        return r;
    endfunction

    state_t                      state_r, state_nxt_s;
    logic signed [DATA_W-1:0]    dline_r [CHANNELS][TAPS];
    logic [PTR_W-1:0]            wptr_r  [CHANNELS];
    logic signed [COEF_W-1:0]    coef_r  [HALF];
    logic [CH_W-1:0]             ch_r;
    logic [K_W-1:0]              k_r;
    logic [PTR_W-1:0]            rd_new_r, rd_old_r;
    logic signed [ACC_W-1:0]     acc_r;

    logic                        in_ready_r, busy_r, out_valid_r, out_sat_r;
    logic [CH_W-1:0]             out_channel_r;
    logic signed [OUT_W-1:0]     out_data_r;

    logic [31:0]                 ch_ext_s;
    logic                        chan_ok_s, accept_s, start_s, mac_en_s, load_out_s;
    logic                        ready_nxt_s, busy_nxt_s;
    logic signed [DATA_W-1:0]    tap_new_s, tap_old_s;
    logic signed [PRE_W-1:0]     pre_s;
    logic signed [PROD_W-1:0]    pre_ext_s, coef_ext_s, prod_s;
    logic [OUT_W:0]              clip_s;

    assign ch_ext_s  = 32'(in_channel);
    assign chan_ok_s = (ch_ext_s < 32'(CHANNELS));
    // in_ready_r is only ever high in IDLE, so a handshake implies IDLE.
    assign accept_s  = in_valid & in_ready_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; an out-of-range channel completes the handshake but stays IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && chan_ok_s) begin
                    state_nxt_s = ST_MAC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MAC: begin
                if (k_r == K_W'(HALF - 1)) begin
                    state_nxt_s = ST_OUT;
                end else begin
                    state_nxt_s = ST_MAC;
                end
            end
            ST_OUT:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output/control decode; ready/busy are decoded from the next state so their registers track it.
    always_comb begin
        start_s     = 1'b0;
        mac_en_s    = 1'b0;
        load_out_s  = 1'b0;
        ready_nxt_s = (state_nxt_s == ST_IDLE);
        busy_nxt_s  = (state_nxt_s == ST_MAC);
        case (state_r)
            ST_IDLE: start_s    = accept_s & chan_ok_s;
            ST_MAC:  mac_en_s   = 1'b1;
            ST_OUT:  load_out_s = 1'b1;
            default: start_s    = 1'b0;
        endcase
    end

    // Shared pre-adder and multiplier: x[k] + x[TAPS-1-k] times h[k].
    always_comb begin
        tap_new_s  = dline_r[ch_r][rd_new_r];
        tap_old_s  = dline_r[ch_r][rd_old_r];
        pre_s      = PRE_W'(tap_new_s) + PRE_W'(tap_old_s);
        pre_ext_s  = PROD_W'(pre_s);
        coef_ext_s = PROD_W'(coef_r[k_r]);
        prod_s     = pre_ext_s * coef_ext_s;
        clip_s     = sat_clip(acc_r);
    end

    // Per-channel delay lines and write pointers; cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wptr_r[c] <= '0;
                for (int t = 0; t < TAPS; t++) begin
                    dline_r[c][t] <= '0;
                end
            end
        end else if (start_s) begin
            dline_r[in_channel][wptr_r[in_channel]] <= in_sample;
            wptr_r[in_channel]                      <= ptr_inc(wptr_r[in_channel]);
        end else begin
            wptr_r <= wptr_r;
        end
    end

    // MAC sequencing: rd_new walks from newest toward older, rd_old from oldest toward newer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_r     <= '0;
            k_r      <= '0;
            rd_new_r <= '0;
            rd_old_r <= '0;
            acc_r    <= '0;
        end else if (start_s) begin
            ch_r     <= in_channel;
            k_r      <= '0;
            rd_new_r <= wptr_r[in_channel];
            rd_old_r <= ptr_inc(wptr_r[in_channel]);
            acc_r    <= '0;
        end else if (mac_en_s) begin
            k_r      <= k_r + K_W'(1);
            rd_new_r <= ptr_dec(rd_new_r);
            rd_old_r <= ptr_inc(rd_old_r);
            acc_r    <= acc_r + ACC_W'(prod_s);
        end else begin
            acc_r    <= acc_r;
        end
    end

    // Coefficient store; not reset, writes accepted only while no MAC is running.
    always_ff @(posedge clk) begin
        if (coef_wr_en && !busy_r) begin
            coef_r[coef_addr] <= coef_data;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r    <= 1'b0;
            busy_r        <= 1'b0;
            out_valid_r   <= 1'b0;
            out_sat_r     <= 1'b0;
            out_channel_r <= '0;
            out_data_r    <= '0;
        end else begin
            in_ready_r  <= ready_nxt_s;
            busy_r      <= busy_nxt_s;
            out_valid_r <= load_out_s;
            if (load_out_s) begin
                out_data_r    <= clip_s[OUT_W-1:0];
                out_sat_r     <= clip_s[OUT_W];
                out_channel_r <= ch_r;
            end else begin
                out_data_r    <= out_data_r;
            end
        end
    end

    assign in_ready    = in_ready_r;
    assign busy        = busy_r;
    assign out_valid   = out_valid_r;
    assign out_sat     = out_sat_r;
    assign out_channel = out_channel_r;
    assign out_data    = out_data_r;

endmodule

// File: tb/tb_eeg_fir_mc.sv
// -----------------------------------------------------------------------------
// tb_eeg_fir_mc
// Directed self-checking bench for eeg_fir_mc (TAPS=64, CHANNELS=4, OUT_W=24).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_eeg_fir_mc;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_channel;
    logic signed [15:0] in_sample;
    logic               coef_wr_en;
    logic [4:0]         coef_addr;
    logic signed [15:0] coef_data;
    logic               out_valid;
    logic [1:0]         out_channel;
    logic signed [23:0] out_data;
    logic               out_sat;
    logic               busy;

    int total;
    int bad;

    eeg_fir_mc #(
        .DATA_W  (16),
        .COEF_W  (16),
        .TAPS    (64),
        .CHANNELS(4),
        .ACC_W   (40),
        .OUT_W   (24)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_channel (in_channel),
        .in_sample  (in_sample),
        .coef_wr_en (coef_wr_en),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .out_valid  (out_valid),
        .out_channel(out_channel),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load every unique coefficient: ramp gives h[k]=k+1, otherwise h[k]=val.
    task automatic load_coefs(input bit ramp, input int val);
        for (int k = 0; k < 32; k++) begin
            coef_wr_en = 1'b1;
            coef_addr  = 5'(k);
            coef_data  = ramp ? 16'(k + 1) : 16'(val);
            tick();
        end
        coef_wr_en = 1'b0;
    endtask

    // Offer one sample, optionally writing a coefficient at accept or at MAC cycle wr_cyc,
    // then wait (bounded) for out_valid. lat=-1 on timeout.
    task automatic send(input int ch, input int smp, input bit wr_acc, input int wr_cyc,
                        input int wa, input int wd,
                        output int lat, output int ready_hits, output int busy_cnt);
        int waitc;
        waitc      = 0;
        lat        = -1;
        ready_hits = 0;
        busy_cnt   = 0;
        while (!in_ready && waitc < 100) begin
            tick();
            waitc++;
        end
        in_valid   = 1'b1;
        in_channel = 2'(ch);
        in_sample  = 16'(smp);
        if (wr_acc) begin
            coef_wr_en = 1'b1;
            coef_addr  = 5'(wa);
            coef_data  = 16'(wd);
        end
        tick();
        in_valid   = 1'b0;
        coef_wr_en = 1'b0;
        if (in_ready) ready_hits++;
        if (busy) busy_cnt++;
        for (int n = 1; n <= 60; n++) begin
            if (wr_cyc == n) begin
                coef_wr_en = 1'b1;
                coef_addr  = 5'(wa);
                coef_data  = 16'(wd);
            end
            tick();
            coef_wr_en = 1'b0;
            if (out_valid) begin
                lat = n;
                break;
            end
            if (in_ready) ready_hits++;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_channel = 2'd0;
        in_sample  = 16'sd0;
        coef_wr_en = 1'b0;
        coef_addr  = 5'd0;
        coef_data  = 16'sd0;
        repeat (3) tick();
        total++; if (in_ready !== 1'b0)   begin bad++; $display("FAIL reset in_ready got=%b exp=0", in_ready); end
        total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL reset out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 24'sd0) begin bad++; $display("FAIL reset out_data got=%0d exp=0", out_data); end
        total++; if (out_channel !== 2'd0) begin bad++; $display("FAIL reset out_channel got=%0d exp=0", out_channel); end
        total++; if (out_sat !== 1'b0)    begin bad++; $display("FAIL reset out_sat got=%b exp=0", out_sat); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset busy got=%b exp=0", busy); end
        rst = 1'b0;
        tick();
        total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL reset_release in_ready got=%b exp=1", in_ready); end
    endtask

    // Impulse into ch0 with h[k]=k+1 (coefficients loaded by the caller).
    task automatic test_impulse(input string tag);
        int lat, rh, bc, exp_v;
        for (int n = 0; n < 64; n++) begin
            send(0, (n == 0) ? 1 : 0, 1'b0, -1, 0, 0, lat, rh, bc);
            exp_v = (n < 32) ? n + 1 : 64 - n;
            total++; if (out_data !== 24'(exp_v)) begin bad++; $display("FAIL %s[%0d] data got=%0d exp=%0d", tag, n, out_data, exp_v); end
            total++; if (out_channel !== 2'd0) begin bad++; $display("FAIL %s[%0d] channel got=%0d exp=0", tag, n, out_channel); end
            total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL %s[%0d] sat got=%b exp=0", tag, n, out_sat); end
            total++; if (lat !== 33) begin bad++; $display("FAIL %s[%0d] latency got=%0d exp=33", tag, n, lat); end
            total++; if (rh !== 0) begin bad++; $display("FAIL %s[%0d] in_ready_during_mac got=%0d exp=0", tag, n, rh); end
            total++; if (bc !== 32) begin bad++; $display("FAIL %s[%0d] busy_cycles got=%0d exp=32", tag, n, bc); end
        end
    endtask

    task automatic test_isolation();
        int lat, rh, bc, exp_v;
        load_coefs(1'b0, 1);
        for (int i = 0; i < 64; i++) begin
            send(2, 100, 1'b0, -1, 0, 0, lat, rh, bc);
            exp_v = 100 * (i + 1);
            total++; if (out_data !== 24'(exp_v)) begin bad++; $display("FAIL iso_ch2[%0d] data got=%0d exp=%0d", i, out_data, exp_v); end
            total++; if (out_channel !== 2'd2) begin bad++; $display("FAIL iso_ch2[%0d] channel got=%0d exp=2", i, out_channel); end
            send(1, 0, 1'b0, -1, 0, 0, lat, rh, bc);
            total++; if (out_data !== 24'sd0) begin bad++; $display("FAIL iso_ch1[%0d] data got=%0d exp=0", i, out_data); end
            total++; if (out_channel !== 2'd1) begin bad++; $display("FAIL iso_ch1[%0d] channel got=%0d exp=1", i, out_channel); end
        end
    endtask

    task automatic test_back_to_back();
        int acc_t[4];
        int ov_t[4];
        int nacc, nout;
        bit pre_ready;
        nacc = 0;
        nout = 0;
        in_valid   = 1'b1;
        in_channel = 2'd0;
        in_sample  = 16'sd0;
        for (int c = 0; c < 300 && nout < 3; c++) begin
            pre_ready = in_ready;
            tick();
            if (pre_ready && nacc < 4) begin acc_t[nacc] = c; nacc++; end
            if (out_valid && nout < 4) begin ov_t[nout] = c; nout++; end
        end
        in_valid = 1'b0;
        total++; if (nacc !== 3) begin bad++; $display("FAIL b2b accept_count got=%0d exp=3", nacc); end
        total++; if (nout !== 3) begin bad++; $display("FAIL b2b out_count got=%0d exp=3", nout); end
        if (nacc == 3 && nout == 3) begin
            for (int i = 0; i < 3; i++) begin
                total++; if (ov_t[i] - acc_t[i] !== 33) begin bad++; $display("FAIL b2b latency[%0d] got=%0d exp=33", i, ov_t[i] - acc_t[i]); end
            end
            for (int i = 1; i < 3; i++) begin
                total++; if (acc_t[i] - acc_t[i-1] !== 34) begin bad++; $display("FAIL b2b spacing[%0d] got=%0d exp=34", i, acc_t[i] - acc_t[i-1]); end
            end
        end
        tick();
    endtask

    task automatic test_saturation();
        int lat, rh, bc;
        load_coefs(1'b0, 32767);
        for (int i = 0; i < 64; i++) begin
            send(0, 32767, 1'b0, -1, 0, 0, lat, rh, bc);
            total++; if (out_data !== 24'h7FFFFF) begin bad++; $display("FAIL sat_pos[%0d] data got=%0d exp=8388607", i, out_data); end
            total++; if (out_sat !== 1'b1) begin bad++; $display("FAIL sat_pos[%0d] sat got=%b exp=1", i, out_sat); end
        end
        for (int i = 0; i < 64; i++) begin
            send(0, -32768, 1'b0, -1, 0, 0, lat, rh, bc);
        end
        total++; if (out_data !== 24'h800000) begin bad++; $display("FAIL sat_neg data got=%0d exp=-8388608", out_data); end
        total++; if (out_sat !== 1'b1) begin bad++; $display("FAIL sat_neg sat got=%b exp=1", out_sat); end
    endtask

    task automatic test_reset_mid_mac();
        int ov_cnt;
        ov_cnt = 0;
        load_coefs(1'b1, 0);
        in_valid   = 1'b1;
        in_channel = 2'd0;
        in_sample  = 16'sd1;
        tick();
        in_valid = 1'b0;
        repeat (10) begin
            tick();
            if (out_valid) ov_cnt++;
        end
        rst = 1'b1;
        tick();
        total++; if (out_data !== 24'sd0)  begin bad++; $display("FAIL midrst out_data got=%0d exp=0", out_data); end
        total++; if (out_channel !== 2'd0) begin bad++; $display("FAIL midrst out_channel got=%0d exp=0", out_channel); end
        total++; if (out_sat !== 1'b0)     begin bad++; $display("FAIL midrst out_sat got=%b exp=0", out_sat); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL midrst busy got=%b exp=0", busy); end
        total++; if (in_ready !== 1'b0)    begin bad++; $display("FAIL midrst in_ready got=%b exp=0", in_ready); end
        tick();
        rst = 1'b0;
        tick();
        total++; if (in_ready !== 1'b1)    begin bad++; $display("FAIL midrst_release in_ready got=%b exp=1", in_ready); end
        repeat (40) begin
            if (out_valid) ov_cnt++;
            tick();
        end
        total++; if (ov_cnt !== 0) begin bad++; $display("FAIL midrst out_valid_pulses got=%0d exp=0", ov_cnt); end
        test_impulse("impulse_after_rst");
    endtask

    task automatic test_coef_busy();
        int lat, rh, bc;
        // h[k]=k+1 on entry; ch3 history is clear
        send(3, 1, 1'b0, 6, 0, 500, lat, rh, bc);
        total++; if (out_data !== 24'sd1) begin bad++; $display("FAIL coef_busy_first got=%0d exp=1", out_data); end
        send(3, 2, 1'b0, -1, 0, 0, lat, rh, bc);
        total++; if (out_data !== 24'sd4) begin bad++; $display("FAIL coef_busy_ignored got=%0d exp=4", out_data); end
        coef_wr_en = 1'b1;
        coef_addr  = 5'd0;
        coef_data  = 16'sd500;
        tick();
        coef_wr_en = 1'b0;
        send(3, 1, 1'b0, -1, 0, 0, lat, rh, bc);
        total++; if (out_data !== 24'sd507) begin bad++; $display("FAIL coef_idle_write got=%0d exp=507", out_data); end
        send(3, 1, 1'b1, -1, 0, 700, lat, rh, bc);
        total++; if (out_data !== 24'sd712) begin bad++; $display("FAIL coef_write_at_accept got=%0d exp=712", out_data); end
        total++; if (out_channel !== 2'd3) begin bad++; $display("FAIL coef_channel got=%0d exp=3", out_channel); end
        total++; if (lat !== 33) begin bad++; $display("FAIL coef_latency got=%0d exp=33", lat); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        load_coefs(1'b1, 0);
        test_impulse("impulse");
        test_isolation();
        test_back_to_back();
        test_saturation();
        test_reset_mid_mac();
        test_coef_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
